// File: rtl/saes_pkg.sv
// Shared S-AES encryption primitives: S-box, GF(2^4) helpers, nibble helpers
// and the control FSM encoding.
package saes_pkg;

  localparam logic [7:0] RCON1_DEF = 8'h80;
  localparam logic [7:0] RCON2_DEF = 8'h30;

  localparam logic [3:0] SBOX [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  typedef enum logic [2:0] {
    IDLE,
    KEY1,
    KEY2,
    RND1,
    RND2,
    DONE
  } state_e;

  // Multiply by x^2 in GF(2^4) mod x^4+x+1: two reduced doublings.
  function automatic logic [3:0] gf_mul4(input logic [3:0] a);
    logic [3:0] t;
    t = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    return {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] sub_nib(input logic [3:0] n);
    return SBOX[n];
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/saes_mix_column_enc.sv
// Forward S-AES MixColumns on both columns, matrix [1 4; 4 1].
module saes_mix_column_enc
  import saes_pkg::*;
(
  input  logic [15:0] din,
  output logic [15:0] dout
);

  assign dout = {din[15:12] ^ gf_mul4(din[11:8]),
                 gf_mul4(din[15:12]) ^ din[11:8],
                 din[7:4] ^ gf_mul4(din[3:0]),
                 gf_mul4(din[7:4]) ^ din[3:0]};

endmodule

// File: rtl/saes_encrypt_core.sv
// Multi-cycle S-AES encryption: key expansion then two rounds on one shared
// datapath, with valid/ready handshakes on both sides.
module saes_encrypt_core
  import saes_pkg::*;
#(
  parameter logic [7:0] RCON1 = RCON1_DEF,
  parameter logic [7:0] RCON2 = RCON2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pt,
  input  logic [15:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ct,
  output logic        busy
);

  state_e      fsm_q, fsm_d;
  logic [15:0] state_reg;
  logic [15:0] key_reg;
  logic [15:0] k1_reg;
  logic [15:0] k2_reg;
  logic [15:0] ct_reg;
  logic [7:0]  w2, w3, w4, w5;
  logic [15:0] sr_sub;
  logic [15:0] mixed;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return {sub_nib(b[7:4]), sub_nib(b[3:0])};
  endfunction

  function automatic logic [15:0] sub_word(input logic [15:0] s);
    return {sub_byte(s[15:8]), sub_byte(s[7:0])};
  endfunction

  function automatic logic [15:0] shift_row(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  // Key schedule halves, each consumed in its own KEY state.
  assign w2 = key_reg[15:8] ^ RCON1 ^ sub_byte(rot_nib(key_reg[7:0]));
  assign w3 = w2 ^ key_reg[7:0];
  assign w4 = k1_reg[15:8] ^ RCON2 ^ sub_byte(rot_nib(k1_reg[7:0]));
  assign w5 = w4 ^ k1_reg[7:0];

  assign sr_sub = shift_row(sub_word(state_reg));

  saes_mix_column_enc u_mix (
    .din  (sr_sub),
    .dout (mixed)
  );

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_ct    = ct_reg;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = KEY1;
      KEY1:    fsm_d = KEY2;
      KEY2:    fsm_d = RND1;
      RND1:    fsm_d = RND2;
      RND2:    fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_reg <= 16'h0000;
      key_reg   <= 16'h0000;
      k1_reg    <= 16'h0000;
      k2_reg    <= 16'h0000;
      ct_reg    <= 16'h0000;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: if (in_valid) begin
          state_reg <= in_pt ^ in_key;
          key_reg   <= in_key;
        end
        KEY1:    k1_reg    <= {w2, w3};
        KEY2:    k2_reg    <= {w4, w5};
        RND1:    state_reg <= mixed ^ k1_reg;
        RND2:    ct_reg    <= sr_sub ^ k2_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_saes_encrypt_core.sv
// Directed and randomized checks of saes_encrypt_core against a nibble-level
// S-AES encryption model.
module tb_saes_encrypt_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pt;
  logic [15:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ct;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int last_acc = 0;

  localparam logic [3:0] SB [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  saes_encrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) n_out <= n_out + 1;
  end

  // Generic polynomial product reduced by x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--)
      if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [7:0] subb(input logic [7:0] b);
    return {SB[b[7:4]], SB[b[3:0]]};
  endfunction

  function automatic logic [15:0] ref_enc(input logic [15:0] pt, input logic [15:0] key);
    logic [7:0]  w [6];
    logic [3:0]  n [4];
    logic [3:0]  t [4];
    logic [3:0]  tmp;
    logic [15:0] s;
    w[0] = key[15:8];
    w[1] = key[7:0];
    w[2] = w[0] ^ 8'h80 ^ subb({w[1][3:0], w[1][7:4]});
    w[3] = w[2] ^ w[1];
    w[4] = w[2] ^ 8'h30 ^ subb({w[3][3:0], w[3][7:4]});
    w[5] = w[4] ^ w[3];
    s = pt ^ key;
    for (int r = 1; r <= 2; r++) begin
      n[0] = SB[s[15:12]]; n[1] = SB[s[11:8]];
      n[2] = SB[s[7:4]];   n[3] = SB[s[3:0]];
      tmp = n[1]; n[1] = n[3]; n[3] = tmp;
      if (r == 1) begin
        t[0] = n[0] ^ gmul(4'h4, n[1]);
        t[1] = gmul(4'h4, n[0]) ^ n[1];
        t[2] = n[2] ^ gmul(4'h4, n[3]);
        t[3] = gmul(4'h4, n[2]) ^ n[3];
        s = {t[0], t[1], t[2], t[3]} ^ {w[2], w[3]};
      end else begin
        s = {n[0], n[1], n[2], n[3]} ^ {w[4], w[5]};
      end
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the core idle; returns at the negedge where
  // out_valid is seen (or right after a mid-block reset when rst_at hits).
  task automatic do_block(input logic [15:0] pt, input logic [15:0] key,
                          input int pulse_at, input int rst_at,
                          output logic [15:0] ct);
    int cnt;
    ct = 16'h0000;
    check("in_ready_idle", 32'(in_ready), 32'h1);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    last_acc = cyc;
    @(negedge clk);
    cnt      = 1;
    in_valid = 1'b0;
    in_pt    = 16'($urandom);
    in_key   = 16'($urandom);
    while (!out_valid && cnt < 20) begin
      if (cnt == pulse_at) begin
        in_valid = 1'b1;
        in_pt    = 16'hFFFF;
        in_key   = 16'hFFFF;
        check("in_ready_busy", 32'(in_ready), 32'h0);
      end
      if (cnt == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_ct", 32'(out_ct), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
    end
    check("latency", 32'(cnt), 32'd5);
    ct = out_ct;
  endtask

  initial begin
    logic [15:0] ct, pt, key;
    int n0, prev_acc;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pt     = 16'h0000;
    in_key    = 16'h0000;
    out_ready = 1'b1;

    @(negedge clk);
    in_valid = 1'b1;
    in_pt    = 16'h6F6B;
    in_key   = 16'hA73B;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_out_ct", 32'(out_ct), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_beats_valid", 32'(busy), 32'h0);

    do_block(16'h6F6B, 16'hA73B, 0, 0, ct);
    check("kat_ct", 32'(ct), 32'h0738);
    @(negedge clk);

    do_block(16'h0000, 16'h0000, 0, 0, ct);
    check("zero_ct", 32'(ct), 32'h071E);
    @(negedge clk);

    out_ready = 1'b0;
    do_block(16'h6F6B, 16'hA73B, 0, 0, ct);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_ct", 32'(out_ct), 32'h0738);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    check("bp_release_out_valid", 32'(out_valid), 32'h0);
    pt  = 16'($urandom);
    key = 16'($urandom);
    do_block(pt, key, 0, 0, ct);
    check("bp_second_ct", 32'(ct), 32'(ref_enc(pt, key)));
    @(negedge clk);

    n0  = n_out;
    pt  = 16'($urandom);
    key = 16'($urandom);
    do_block(pt, key, 2, 0, ct);
    check("busy_pulse_ct", 32'(ct), 32'(ref_enc(pt, key)));
    repeat (8) @(negedge clk);
    check("busy_pulse_outputs", 32'(n_out - n0), 32'd1);
    check("busy_pulse_idle", 32'(busy), 32'h0);

    n0 = n_out;
    do_block(16'h6F6B, 16'hA73B, 0, 3, ct);
    repeat (8) @(negedge clk);
    check("rst_mid_no_output", 32'(n_out - n0), 32'd0);
    do_block(16'h6F6B, 16'hA73B, 0, 0, ct);
    check("rst_mid_recover_ct", 32'(ct), 32'h0738);
    @(negedge clk);

    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      pt  = 16'($urandom);
      key = 16'($urandom);
      do_block(pt, key, 0, 0, ct);
      check("b2b_ct", 32'(ct), 32'(ref_enc(pt, key)));
      if (i > 0) check("b2b_spacing", 32'(last_acc - prev_acc), 32'd6);
      prev_acc = last_acc;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
